// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the SAP controller-sequencer: opcodes, control bit map,
// per-opcode instruction length and the microcode ROM expressed as a function.
// No ports; imported by sap_ring_counter and sap_controller.
package sap_ctrl_pkg;

  localparam int CW_W  = 16;  // control word width
  localparam int T_W   = 3;   // T-state counter width
  localparam int T_MAX = 4;   // highest legal T-state (T4)

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CW_EP  = 0;
  localparam int CW_CP  = 1;
  localparam int CW_J   = 2;
  localparam int CW_MI  = 3;
  localparam int CW_RO  = 4;
  localparam int CW_RI  = 5;
  localparam int CW_II  = 6;
  localparam int CW_IO  = 7;
  localparam int CW_AIN = 8;
  localparam int CW_ALI = 9;   // load operand nibble into A[3:0]
  localparam int CW_AO  = 10;
  localparam int CW_BI  = 11;
  localparam int CW_EU  = 12;
  localparam int CW_SU  = 13;
  localparam int CW_FI  = 14;
  localparam int CW_OI  = 15;

  // Number of T-states (T0..) the instruction occupies. Undefined opcodes act as NOP.
  function automatic logic [T_W-1:0] op_len(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA:                                   op_len = 3'd4;
      OP_ADD, OP_SUB:                                   op_len = 3'd5;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:     op_len = 3'd3;
      default:                                          op_len = 3'd2;
    endcase
  endfunction

  // Control word for a given opcode/T-state. Flags only matter in T2 (conditional jumps).
  function automatic logic [CW_W-1:0] ucode(input logic [3:0]     op,
                                            input logic [T_W-1:0] t,
                                            input logic           fc,
                                            input logic           fz);
    logic [CW_W-1:0] w;
    w = '0;
    case (t)
      3'd0: begin
        w[CW_EP] = 1'b1; w[CW_MI] = 1'b1;
      end
      3'd1: begin
        w[CW_RO] = 1'b1; w[CW_II] = 1'b1; w[CW_CP] = 1'b1;
      end
      3'd2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w[CW_IO] = 1'b1; w[CW_MI] = 1'b1;
          end
          OP_LDI: begin
            w[CW_IO] = 1'b1; w[CW_ALI] = 1'b1;
          end
          OP_JMP: begin
            w[CW_IO] = 1'b1; w[CW_J] = 1'b1;
          end
          OP_JC: begin
            w[CW_IO] = fc; w[CW_J] = fc;
          end
          OP_JZ: begin
            w[CW_IO] = fz; w[CW_J] = fz;
          end
          OP_OUT: begin
            w[CW_AO] = 1'b1; w[CW_OI] = 1'b1;
          end
          default: w = '0;
        endcase
      end
      3'd3: begin
        case (op)
          OP_LDA: begin
            w[CW_RO] = 1'b1; w[CW_AIN] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w[CW_RO] = 1'b1; w[CW_BI] = 1'b1;
          end
          OP_STA: begin
            w[CW_AO] = 1'b1; w[CW_RI] = 1'b1;
          end
          default: w = '0;
        endcase
      end
      3'd4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          w[CW_EU]  = 1'b1; w[CW_AIN] = 1'b1; w[CW_FI] = 1'b1;
          w[CW_SU]  = (op == OP_SUB);
        end
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// T-state counter: synchronous clear, count enable, and a guard that returns
// any illegal value (above T_MAX) to T0 on the next edge.
// Ports: clk, clr (sync clear, highest priority), en (advance), count (current T-state).
module sap_ring_counter
  import sap_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           en,
  output logic [T_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (count > T_W'(T_MAX)) begin
      // Unreachable in normal operation; recover regardless of en.
      count <= '0;
    end else if (en) begin
      count <= count + T_W'(1);
    end
  end

endmodule

// File: rtl/sap_controller.sv
// SAP controller-sequencer: T-state sequencing, microcode decode, halt and run gating.
// Ports: clk, rst (sync, active high), run, opcode, flag_c, flag_z in;
//        ctrl (16-bit control word), tstate, instr_done, halted out.
module sap_controller
  import sap_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [3:0]      opcode,
  input  logic            flag_c,
  input  logic            flag_z,
  output logic [CW_W-1:0] ctrl,
  output logic [T_W-1:0]  tstate,
  output logic            instr_done,
  output logic            halted
);

  logic adv;        // sequencer is allowed to act this cycle
  logic last;       // current T-state is the final one for this opcode
  logic hlt_stop;   // HLT reaching its final state: latch halt, freeze tstate
  logic cnt_clr;
  logic cnt_en;

  always_comb begin
    adv      = run & ~halted;
    last     = (tstate == (op_len(opcode) - T_W'(1)));
    hlt_stop = adv & last & (opcode == OP_HLT);
    // HLT must not wrap to T0: tstate stays at 2 while halted.
    cnt_clr  = rst | (adv & last & ~hlt_stop);
    cnt_en   = adv & ~hlt_stop;
  end

  sap_ring_counter u_ring (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (tstate)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (hlt_stop) begin
      halted <= 1'b1;
    end
  end

  // Gating with run keeps a paused T-state from repeating Cp or register loads.
  always_comb begin
    ctrl       = '0;
    instr_done = 1'b0;
    if (adv) begin
      ctrl       = ucode(opcode, tstate, flag_c, flag_z);
      instr_done = last;
    end
  end

endmodule

// File: tb/tb_sap_controller.sv
module tb_sap_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] ctrl;
  logic [2:0]  tstate;
  logic        instr_done;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  sap_controller dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .ctrl       (ctrl),
    .tstate     (tstate),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Run one full instruction with run=1. w[t] is the expected word in Tt.
  task automatic run_instr(input string tag, input logic [3:0] op, input int len,
                           input logic [4:0][15:0] w);
    opcode = op;
    run    = 1'b1;
    for (int t = 0; t < len; t++) begin
      #1;
      check_eq({tag, "_tstate"}, {13'd0, tstate}, 16'(t));
      check_eq({tag, "_ctrl"}, ctrl, w[t]);
      check_eq({tag, "_done"}, {15'd0, instr_done}, (t == len - 1) ? 16'd1 : 16'd0);
      tick();
    end
    #1;
    check_eq({tag, "_wrap"}, {13'd0, tstate}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    #2;
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_tstate", {13'd0, tstate}, 16'd0);
    check_eq("rst_ctrl",   ctrl, 16'h0009);
    check_eq("rst_halted", {15'd0, halted}, 16'd0);
    check_eq("rst_done",   {15'd0, instr_done}, 16'd0);

    run_instr("lda", 4'h1, 4, {16'h0000, 16'h0110, 16'h0088, 16'h0052, 16'h0009});
    run_instr("add", 4'h2, 5, {16'h5100, 16'h0810, 16'h0088, 16'h0052, 16'h0009});
    run_instr("sub", 4'h3, 5, {16'h7100, 16'h0810, 16'h0088, 16'h0052, 16'h0009});
    run_instr("sta", 4'h4, 4, {16'h0000, 16'h0420, 16'h0088, 16'h0052, 16'h0009});
    run_instr("ldi", 4'h5, 3, {16'h0000, 16'h0000, 16'h0280, 16'h0052, 16'h0009});
    run_instr("jmp", 4'h6, 3, {16'h0000, 16'h0000, 16'h0084, 16'h0052, 16'h0009});
    run_instr("out", 4'hE, 3, {16'h0000, 16'h0000, 16'h8400, 16'h0052, 16'h0009});
    run_instr("nop", 4'h0, 2, {16'h0000, 16'h0000, 16'h0000, 16'h0052, 16'h0009});
    run_instr("undef", 4'hA, 2, {16'h0000, 16'h0000, 16'h0000, 16'h0052, 16'h0009});
    flag_c = 1'b0;
    run_instr("jc0", 4'h7, 3, {16'h0000, 16'h0000, 16'h0000, 16'h0052, 16'h0009});
    flag_c = 1'b1;
    run_instr("jc1", 4'h7, 3, {16'h0000, 16'h0000, 16'h0084, 16'h0052, 16'h0009});
    flag_c = 1'b0;

    // JZ: flag changes within T2 are reflected immediately.
    opcode = 4'h8; flag_z = 1'b0;
    tick(); tick();
    #1;
    check_eq("jz_t2_z0", ctrl, 16'h0000);
    flag_z = 1'b1;
    #1;
    check_eq("jz_t2_z1", ctrl, 16'h0084);
    check_eq("jz_done",  {15'd0, instr_done}, 16'd1);
    flag_z = 1'b0;
    #1;
    check_eq("jz_t2_z0b", ctrl, 16'h0000);
    tick();
    #1;
    check_eq("jz_wrap", {13'd0, tstate}, 16'd0);

    // Pause at T1 for three clocks, then resume.
    opcode = 4'h1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("pause_tstate", {13'd0, tstate}, 16'd1);
      check_eq("pause_ctrl",   ctrl, 16'h0000);
      check_eq("pause_done",   {15'd0, instr_done}, 16'd0);
      tick();
    end
    run = 1'b1;
    #1;
    check_eq("resume_t1", ctrl, 16'h0052);
    tick();
    #1;
    check_eq("resume_t2_ctrl",   ctrl, 16'h0088);
    check_eq("resume_t2_tstate", {13'd0, tstate}, 16'd2);
    tick(); tick();
    #1;
    check_eq("resume_wrap", {13'd0, tstate}, 16'd0);

    // Reset in the middle of ADD (at T3).
    opcode = 4'h2;
    tick(); tick(); tick();
    #1;
    check_eq("add_t3_pre_rst", ctrl, 16'h0810);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_tstate", {13'd0, tstate}, 16'd0);
    check_eq("midrst_ctrl",   ctrl, 16'h0009);

    // HLT: halts at end of T2 and stays there until reset, regardless of run.
    opcode = 4'hF;
    tick(); tick();
    #1;
    check_eq("hlt_t2_ctrl",   ctrl, 16'h0000);
    check_eq("hlt_t2_done",   {15'd0, instr_done}, 16'd1);
    check_eq("hlt_t2_halted", {15'd0, halted}, 16'd0);
    tick();
    for (int i = 0; i < 12; i++) begin
      run = (i % 3 != 1);
      #1;
      check_eq("halt_flag",   {15'd0, halted}, 16'd1);
      check_eq("halt_ctrl",   ctrl, 16'h0000);
      check_eq("halt_tstate", {13'd0, tstate}, 16'd2);
      check_eq("halt_done",   {15'd0, instr_done}, 16'd0);
      tick();
    end
    run = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("unhalt_tstate", {13'd0, tstate}, 16'd0);
    check_eq("unhalt_halted", {15'd0, halted}, 16'd0);
    check_eq("unhalt_ctrl",   ctrl, 16'h0009);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
